// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, sync/blank generation and
// a one-tick registered colour stage aligned with the registered sync outputs.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       pix_ce,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             visible;
  logic             h_sync_active;
  logic             v_sync_active;

  always_comb begin
    div_next = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Decode of the current (held) raster position; feeds the output stage on pix_ce.
  assign pix_ce        = (div_cnt == DIV_LAST);
  assign frame_start   = pix_ce && (h_counter == 10'd0) && (v_counter == 10'd0);
  assign visible       = (h_counter < H_VIS) && (v_counter < V_VIS);
  assign h_sync_active = (h_counter >= H_SYNC_START) && (h_counter < H_SYNC_END);
  assign v_sync_active = (v_counter >= V_SYNC_START) && (v_counter < V_SYNC_END);
  assign VGA_SYNC_N    = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= '0;
      h_counter   <= 10'd0;
      v_counter   <= 10'd0;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      div_cnt <= div_next;
      VGA_CLK <= (div_next >= DIV_HALF);
      if (pix_ce) begin
        if (h_counter == H_LAST) begin
          h_counter <= 10'd0;
          v_counter <= (v_counter == V_LAST) ? 10'd0 : v_counter + 10'd1;
        end else begin
          h_counter <= h_counter + 10'd1;
        end
        VGA_R       <= visible ? R_in : 8'h00;
        VGA_G       <= visible ? G_in : 8'h00;
        VGA_B       <= visible ? B_in : 8'h00;
        VGA_BLANK_N <= visible;
        VGA_HS      <= !h_sync_active;
        VGA_VS      <= !v_sync_active;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster; a reference model pushes the
// expected registered pixel per tick into a queue that the tests pop and compare.
module tb_vga_timing_gen;

  localparam int unsigned DIV = 4;
  localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME = DIV * HT * VT;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       blank;
    logic       hs;
    logic       vs;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ramp_mode = 1'b0;
  logic [7:0] r_drive = 8'h00, g_drive = 8'h00, b_drive = 8'h00;
  logic [7:0] R_in, G_in, B_in;
  logic [9:0] h_counter, v_counter;
  logic       pix_ce, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
  pix_t       act;

  int   checks = 0;
  int   passed = 0;
  int   m_div = 0, m_h = 0, m_v = 0;
  logic m_vclk = 1'b0;
  pix_t exp_q[$];
  pix_t cur;
  bit   popped;

  assign R_in = ramp_mode ? h_counter[7:0] : r_drive;
  assign G_in = g_drive;
  assign B_in = b_drive;
  assign act  = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .h_counter(h_counter), .v_counter(v_counter), .pix_ce(pix_ce),
    .frame_start(frame_start), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  // Reference raster: pushes the expected output-stage contents at every pixel tick.
  always @(posedge clk) begin
    pix_t e;
    int   nd;
    logic vis;
    if (!reset) begin
      m_div  <= 0;
      m_h    <= 0;
      m_v    <= 0;
      m_vclk <= 1'b0;
      exp_q.delete();
      e = {24'h000000, 1'b0, 1'b1, 1'b1};
      exp_q.push_back(e);
    end else begin
      nd = (m_div == DIV - 1) ? 0 : m_div + 1;
      m_div  <= nd;
      m_vclk <= (nd >= DIV / 2);
      if (m_div == DIV - 1) begin
        vis     = (m_h < HV) && (m_v < VV);
        e.r     = vis ? (ramp_mode ? 8'(m_h) : r_drive) : 8'h00;
        e.g     = vis ? g_drive : 8'h00;
        e.b     = vis ? b_drive : 8'h00;
        e.blank = vis;
        e.hs    = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
        e.vs    = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
        exp_q.push_back(e);
        if (m_h == HT - 1) begin
          m_h <= 0;
          m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h <= m_h + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    popped = 1'b0;
    if (exp_q.size() > 0) begin
      cur    = exp_q.pop_front();
      popped = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if ({h_counter, v_counter, pix_ce, frame_start, VGA_CLK} !== 23'd0)
      $display("FAIL reset_counters: got h=%0d v=%0d ce=%b fs=%b vclk=%b required all 0",
               h_counter, v_counter, pix_ce, frame_start, VGA_CLK);
    else passed++;
    checks++;
    if ({act, VGA_SYNC_N} !== {24'h000000, 3'b011, 1'b0})
      $display("FAIL reset_outputs: got %h sync_n=%b required %h sync_n=0",
               act, VGA_SYNC_N, {24'h000000, 3'b011});
    else passed++;
    reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (pix_ce !== 1'b1 && n < 4 * DIV);
    checks++;
    if (n != DIV - 1) $display("FAIL first_pix_ce: got %0d clk required %0d", n, DIV - 1);
    else passed++;
    checks++;
    if (frame_start !== 1'b1) $display("FAIL first_frame_start: got %b required 1", frame_start);
    else passed++;
    tick();
    checks++;
    if ({h_counter, v_counter, frame_start} !== {10'd1, 10'd0, 1'b0})
      $display("FAIL first_advance: got h=%0d v=%0d fs=%b required h=1 v=0 fs=0",
               h_counter, v_counter, frame_start);
    else passed++;
  endtask

  task automatic test_divider();
    int hi = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      tick();
      checks++;
      if ({pix_ce, VGA_CLK} !== {(m_div == DIV - 1), m_vclk})
        $display("FAIL divider: got ce=%b vclk=%b required ce=%b vclk=%b",
                 pix_ce, VGA_CLK, (m_div == DIV - 1), m_vclk);
      else passed++;
      if (VGA_CLK === 1'b1) hi++;
    end
    checks++;
    if (hi != 2 * DIV) $display("FAIL vga_clk_duty: got %0d high clk required %0d", hi, 2 * DIV);
    else passed++;
  endtask

  task automatic test_line();
    int   cyc = 0, pops = 0, hs_low = 0;
    logic prev_hs;
    while (!(pix_ce === 1'b1 && h_counter === 10'(HT - 1)) && cyc < 2 * FRAME) begin
      tick();
      cyc++;
    end
    tick();
    checks++;
    if ({h_counter, v_counter} !== {10'd0, 10'd1})
      $display("FAIL line_wrap: got h=%0d v=%0d required h=0 v=1", h_counter, v_counter);
    else passed++;
    prev_hs = act.hs;
    while (pops < HT && cyc < 2 * FRAME) begin
      tick();
      cyc++;
      checks++;
      if ({h_counter, v_counter} !== {10'(m_h), 10'(m_v)})
        $display("FAIL line_counters: got h=%0d v=%0d required h=%0d v=%0d",
                 h_counter, v_counter, m_h, m_v);
      else passed++;
      if (popped) begin
        pops++;
        checks++;
        if (act !== cur) $display("FAIL line_pixel: got %h required %h", act, cur);
        else passed++;
        if (act.hs === 1'b0) hs_low++;
        if (prev_hs === 1'b1 && act.hs === 1'b0) begin
          checks++;
          if (h_counter !== 10'(HV + HF + 1))
            $display("FAIL hs_fall: got h=%0d required h=%0d", h_counter, HV + HF + 1);
          else passed++;
        end
        prev_hs = act.hs;
      end
    end
    checks++;
    if (pops != HT) $display("FAIL line_ticks: got %0d required %0d", pops, HT);
    else passed++;
    checks++;
    if (hs_low != HS) $display("FAIL hs_width: got %0d ticks required %0d", hs_low, HS);
    else passed++;
  endtask

  task automatic test_frame();
    int   cyc = 0, start, pops = 0, vs_low = 0, max_v = 0;
    logic prev_vs;
    while (frame_start !== 1'b1 && cyc < 2 * FRAME) begin
      tick();
      cyc++;
    end
    start   = cyc;
    prev_vs = act.vs;
    do begin
      tick();
      cyc++;
      if (int'(v_counter) > max_v) max_v = int'(v_counter);
      if (popped) begin
        pops++;
        checks++;
        if (act !== cur) $display("FAIL frame_pixel: got %h required %h", act, cur);
        else passed++;
        if (act.vs === 1'b0) vs_low++;
        if (prev_vs === 1'b1 && act.vs === 1'b0) begin
          checks++;
          if ({h_counter, v_counter} !== {10'd1, 10'(VV + VF)})
            $display("FAIL vs_start: got h=%0d v=%0d required h=1 v=%0d",
                     h_counter, v_counter, VV + VF);
          else passed++;
        end
        prev_vs = act.vs;
      end
    end while (frame_start !== 1'b1 && cyc < 4 * FRAME);
    checks++;
    if (cyc - start != FRAME) $display("FAIL frame_period: got %0d clk required %0d", cyc - start, FRAME);
    else passed++;
    checks++;
    if (pops != HT * VT) $display("FAIL frame_ticks: got %0d required %0d", pops, HT * VT);
    else passed++;
    checks++;
    if (vs_low != VS * HT) $display("FAIL vs_width: got %0d ticks required %0d", vs_low, VS * HT);
    else passed++;
    checks++;
    if (max_v != VT - 1) $display("FAIL v_max: got %0d required %0d", max_v, VT - 1);
    else passed++;
    checks++;
    if ({h_counter, v_counter} !== 20'd0)
      $display("FAIL v_wrap: got h=%0d v=%0d required 0 0", h_counter, v_counter);
    else passed++;
  endtask

  task automatic test_blank();
    int cyc = 0, pops = 0, vis = 0, ff = 0;
    r_drive = 8'hFF;
    g_drive = 8'hFF;
    b_drive = 8'hFF;
    while (pops < HT * VT && cyc < 2 * FRAME) begin
      tick();
      cyc++;
      if (popped) begin
        pops++;
        checks++;
        if (act !== cur) $display("FAIL blank_pixel: got %h required %h", act, cur);
        else passed++;
        if (act.blank === 1'b1) vis++;
        if (VGA_R === 8'hFF) ff++;
      end
    end
    checks++;
    if (vis != HV * VV) $display("FAIL blank_count: got %0d required %0d", vis, HV * VV);
    else passed++;
    checks++;
    if (ff != HV * VV) $display("FAIL ff_count: got %0d required %0d", ff, HV * VV);
    else passed++;
  endtask

  task automatic test_pipeline();
    int cyc = 0, pops = 0;
    ramp_mode = 1'b1;
    g_drive   = 8'h3C;
    b_drive   = 8'hC3;
    while (pops < 2 * HT && cyc < 2 * FRAME) begin
      tick();
      cyc++;
      if (popped) begin
        pops++;
        checks++;
        if (act !== cur) $display("FAIL ramp_pixel: got %h required %h", act, cur);
        else passed++;
      end
    end
    checks++;
    if (pops != 2 * HT) $display("FAIL ramp_ticks: got %0d required %0d", pops, 2 * HT);
    else passed++;
    ramp_mode = 1'b0;
  endtask

  task automatic test_midframe_reset();
    r_drive = 8'h5A;
    g_drive = 8'hA5;
    b_drive = 8'h11;
    for (int t = 0; t < 2; t++) begin
      int th, tv, cyc, n;
      th  = (t == 0) ? 10 : HV + HF + 2;
      tv  = (t == 0) ? 7 : VV + VF;
      cyc = 0;
      while (!(m_h == th && m_v == tv) && cyc < 2 * FRAME) begin
        tick();
        cyc++;
      end
      checks++;
      if ({h_counter, v_counter} !== {10'(th), 10'(tv)})
        $display("FAIL mid_target: got h=%0d v=%0d required h=%0d v=%0d",
                 h_counter, v_counter, th, tv);
      else passed++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if ({h_counter, v_counter, pix_ce, frame_start} !== 22'd0)
        $display("FAIL mid_reset_counters: got h=%0d v=%0d ce=%b fs=%b required all 0",
                 h_counter, v_counter, pix_ce, frame_start);
      else passed++;
      checks++;
      if (act !== {24'h000000, 3'b011})
        $display("FAIL mid_reset_outputs: got %h required %h", act, {24'h000000, 3'b011});
      else passed++;
      n = 0;
      do begin
        tick();
        n++;
      end while (pix_ce !== 1'b1 && n < 4 * DIV);
      checks++;
      if (n != DIV - 1 || frame_start !== 1'b1)
        $display("FAIL mid_restart: got %0d clk fs=%b required %0d clk fs=1", n, frame_start, DIV - 1);
      else passed++;
      for (int i = 0; i < HT * DIV; i++) begin
        tick();
        checks++;
        if ({h_counter, v_counter} !== {10'(m_h), 10'(m_v)})
          $display("FAIL mid_counters: got h=%0d v=%0d required h=%0d v=%0d",
                   h_counter, v_counter, m_h, m_v);
        else passed++;
        if (popped) begin
          checks++;
          if (act !== cur) $display("FAIL mid_pixel: got %h required %h", act, cur);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_line();
    test_frame();
    test_blank();
    test_pipeline();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
